// File: rtl/bp_resolve_tracker.sv
// bp_resolve_tracker
// Resolution-side companion to the perceptron branch predictor. Every
// prediction issued by fetch is queued in program order; each resolve from
// execute pops the oldest one, compares it against the real outcome and
// emits a registered training strobe, a mispredict redirect and saturating
// accuracy statistics.

module bp_resolve_tracker #(
    parameter int Depth    = 4,
    parameter int CntWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    // prediction stream from fetch
    input  logic                pred_valid_i,
    input  logic [31:0]         pred_pc_i,
    input  logic                pred_taken_i,
    input  logic [31:0]         pred_target_i,
    input  logic                pred_compressed_i,
    output logic                pred_ready_o,

    // resolution from execute
    input  logic                ex_resolve_valid_i,
    input  logic                ex_taken_i,
    input  logic [31:0]         ex_target_i,
    input  logic                flush_i,

    // training stream back to the predictor
    output logic                ex_br_valid_o,
    output logic [31:0]         ex_br_instr_addr_o,
    output logic                ex_br_taken_o,

    // redirect and statistics
    output logic                mispredict_o,
    output logic [31:0]         redirect_pc_o,
    output logic                underflow_o,
    output logic [CntWidth-1:0] branch_cnt_o,
    output logic [CntWidth-1:0] mispredict_cnt_o
);

    localparam int PtrW = $clog2(Depth);

    localparam logic [PtrW-1:0]     PtrOne    = PtrW'(1);
    localparam logic [PtrW:0]       CountOne  = (PtrW + 1)'(1);
    localparam logic [PtrW:0]       CountFull = (PtrW + 1)'(Depth);
    localparam logic [CntWidth-1:0] CntOne    = CntWidth'(1);
    localparam logic [CntWidth-1:0] CntMax    = '1;

    // in-flight prediction storage, one field per array
    logic [31:0]     pc_mem     [Depth];
    logic            taken_mem  [Depth];
    logic [31:0]     target_mem [Depth];
    logic            comp_mem   [Depth];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q,  count_d;

    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            clear;

    logic [31:0]     head_pc;
    logic            head_taken;
    logic [31:0]     head_target;
    logic            head_comp;

    logic [31:0]     fall_through;
    logic [31:0]     correct_pc;
    logic            dir_wrong;
    logic            target_wrong;
    logic            mis;

    // Ready depends on occupancy alone so fetch never sees a loop through pred_valid_i.
    always_comb begin
        pred_ready_o = (count_q != CountFull);
        fifo_empty   = (count_q == '0);
    end

    // Read the oldest entry and decide whether it was predicted correctly.
    always_comb begin
        head_pc      = pc_mem[rd_ptr_q];
        head_taken   = taken_mem[rd_ptr_q];
        head_target  = target_mem[rd_ptr_q];
        head_comp    = comp_mem[rd_ptr_q];

        pop          = ex_resolve_valid_i & ~fifo_empty;
        fall_through = head_pc + (head_comp ? 32'd2 : 32'd4);
        correct_pc   = ex_taken_i ? ex_target_i : fall_through;
        dir_wrong    = (ex_taken_i != head_taken);
        target_wrong = ex_taken_i & head_taken & (ex_target_i != head_target);
        mis          = pop & (dir_wrong | target_wrong);
    end

    // A mispredict or external flush makes everything still queued wrong-path,
    // including anything fetch offers this cycle.
    always_comb begin
        clear = mis | flush_i;
        push  = pred_valid_i & pred_ready_o & ~clear;
    end

    // Next pointer and occupancy; a simultaneous push and pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CountOne;
                2'b01:   count_d = count_q - CountOne;
                default: count_d = count_q;
            endcase
        end
    end

    // Entry storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr_q]     <= pred_pc_i;
            taken_mem[wr_ptr_q]  <= pred_taken_i;
            target_mem[wr_ptr_q] <= pred_target_i;
            comp_mem[wr_ptr_q]   <= pred_compressed_i;
        end
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Single-cycle strobes; address, direction and redirect hold between resolves.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_br_valid_o      <= 1'b0;
            mispredict_o       <= 1'b0;
            ex_br_instr_addr_o <= '0;
            ex_br_taken_o      <= 1'b0;
            redirect_pc_o      <= '0;
        end else begin
            ex_br_valid_o <= pop;
            mispredict_o  <= mis;
            if (pop) begin
                ex_br_instr_addr_o <= head_pc;
                ex_br_taken_o      <= ex_taken_i;
                redirect_pc_o      <= correct_pc;
            end
        end
    end

    // Sticky flag for a resolve that found nothing in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            underflow_o <= 1'b0;
        end else if (ex_resolve_valid_i && fifo_empty) begin
            underflow_o <= 1'b1;
        end
    end

    // Saturating resolve and mispredict counters, updated alongside the strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_cnt_o     <= '0;
            mispredict_cnt_o <= '0;
        end else begin
            if (pop && (branch_cnt_o != CntMax)) begin
                branch_cnt_o <= branch_cnt_o + CntOne;
            end
            if (mis && (mispredict_cnt_o != CntMax)) begin
                mispredict_cnt_o <= mispredict_cnt_o + CntOne;
            end
        end
    end

endmodule
